// File: rtl/m_stage_pkg.sv
// Shared decode for the M stage: opcode/funct encodings, memory-op classification
// and the pipeline-register bundle latched from E.
package m_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef enum logic [3:0] {
        MOP_NONE,
        MOP_LW,
        MOP_LH,
        MOP_LHU,
        MOP_LB,
        MOP_LBU,
        MOP_SW,
        MOP_SH,
        MOP_SB
    } mem_op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  reg_addr;
        logic        reg_write;
        logic [2:0]  tnew;
    } m_regs_t;

    function automatic mem_op_e decode_mem_op(input logic [5:0] opcode);
        case (opcode)
            OP_LW:   return MOP_LW;
            OP_LH:   return MOP_LH;
            OP_LHU:  return MOP_LHU;
            OP_LB:   return MOP_LB;
            OP_LBU:  return MOP_LBU;
            OP_SW:   return MOP_SW;
            OP_SH:   return MOP_SH;
            OP_SB:   return MOP_SB;
            default: return MOP_NONE;
        endcase
    endfunction

    function automatic logic is_link(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_JAL) || (opcode == OP_SPECIAL && funct == FN_JALR);
    endfunction

endpackage

// File: rtl/m_stage_reg.sv
// E->M pipeline latch; loads every cycle, asynchronously cleared by reset.
module m_stage_reg
    import m_stage_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  m_regs_t d,
    output m_regs_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/m_stage.sv
// MIPS memory stage: E->M latch, byte-enabled data memory with load extension,
// W->M store-data forwarding. Define DM_DISPLAY_EN to log every committed store.
module m_stage
    import m_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_Instr,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_PC8,
    input  logic [31:0] ALUResult,
    input  logic [31:0] E_RD2,
    input  logic [4:0]  E_RegAddr,
    input  logic        E_RegWrite,
    input  logic [2:0]  E_Tnew,
    input  logic [31:0] W_RegData,
    input  logic [4:0]  W_RegAddr,
    input  logic        W_RegWrite,
    output logic [31:0] M_Instr,
    output logic [31:0] M_PC,
    output logic [31:0] M_PC8,
    output logic [31:0] M_ALUResult,
    output logic [31:0] M_DMRD,
    output logic [31:0] M_RegData,
    output logic [4:0]  M_RegAddr,
    output logic        M_RegWrite,
    output logic [2:0]  M_Tnew
);

    m_regs_t     e_bus;
    m_regs_t     m_bus;
    mem_op_e     op;
    logic [4:0]  rt;
    logic [31:0] store_data;
    logic [11:0] idx;
    logic        in_range;
    logic        commit;
    logic [31:0] cur_word;
    logic [31:0] merged;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] mem [DM_WORDS];

    always_comb begin
        e_bus           = '0;
        e_bus.instr     = E_Instr;
        e_bus.pc        = E_PC;
        e_bus.pc8       = E_PC8;
        e_bus.alu       = ALUResult;
        e_bus.rd2       = E_RD2;
        e_bus.reg_addr  = E_RegAddr;
        e_bus.reg_write = E_RegWrite;
        e_bus.tnew      = (E_Tnew == '0) ? '0 : E_Tnew - 3'd1;
    end

    m_stage_reg u_reg (
        .clk   (clk),
        .reset (reset),
        .d     (e_bus),
        .q     (m_bus)
    );

    assign M_Instr     = m_bus.instr;
    assign M_PC        = m_bus.pc;
    assign M_PC8       = m_bus.pc8;
    assign M_ALUResult = m_bus.alu;
    assign M_RegAddr   = m_bus.reg_addr;
    assign M_RegWrite  = m_bus.reg_write;
    assign M_Tnew      = m_bus.tnew;
    assign M_RegData   = is_link(m_bus.instr[31:26], m_bus.instr[5:0]) ? m_bus.pc8 : m_bus.alu;

    assign op = decode_mem_op(m_bus.instr[31:26]);
    assign rt = m_bus.instr[20:16];

    // W result overrides the rd2 value captured in E when it targets this store's rt.
    assign store_data = (rt != 5'd0 && W_RegWrite && W_RegAddr == rt) ? W_RegData : m_bus.rd2;

    assign idx      = m_bus.alu[13:2];
    assign in_range = 32'(idx) < DM_WORDS;
    assign cur_word = in_range ? mem[idx] : '0;
    assign commit   = in_range && (op == MOP_SW || op == MOP_SH || op == MOP_SB);

    always_comb begin
        merged = cur_word;
        case (op)
            MOP_SW:  merged = store_data;
            MOP_SH:  merged[{m_bus.alu[1], 4'b0000} +: 16] = store_data[15:0];
            MOP_SB:  merged[{m_bus.alu[1:0], 3'b000} +: 8] = store_data[7:0];
            default: merged = cur_word;
        endcase
    end

    assign half_v = cur_word[{m_bus.alu[1], 4'b0000} +: 16];
    assign byte_v = cur_word[{m_bus.alu[1:0], 3'b000} +: 8];

    always_comb begin
        M_DMRD = '0;
        case (op)
            MOP_LW:  M_DMRD = cur_word;
            MOP_LH:  M_DMRD = {{16{half_v[15]}}, half_v};
            MOP_LHU: M_DMRD = {16'h0000, half_v};
            MOP_LB:  M_DMRD = {{24{byte_v[7]}}, byte_v};
            MOP_LBU: M_DMRD = {24'h000000, byte_v};
            default: M_DMRD = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[idx] <= merged;
`ifdef DM_DISPLAY_EN
            $display("%d@%h: *%h <= %h", $time, M_PC, {m_bus.alu[31:2], 2'b00}, merged);
`endif
        end
    end

endmodule
